// File: rtl/decode_execute_latch.sv
// Decode/execute pipeline latch with load-use bubble insertion and deferred flush.
// Optional `PERF_CNT_EN adds a saturating load-use bubble counter output.

package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE  = 6'b000000,
    REGIMM = 6'b000001,
    J      = 6'b000010,
    JAL    = 6'b000011,
    BEQ    = 6'b000100,
    BNE    = 6'b000101,
    BLEZ   = 6'b000110,
    BGTZ   = 6'b000111,
    ADDI   = 6'b001000,
    ADDIU  = 6'b001001,
    SLTI   = 6'b001010,
    SLTIU  = 6'b001011,
    ANDI   = 6'b001100,
    ORI    = 6'b001101,
    XORI   = 6'b001110,
    LUI    = 6'b001111,
    LB     = 6'b100000,
    LH     = 6'b100001,
    LW     = 6'b100011,
    LBU    = 6'b100100,
    LHU    = 6'b100101,
    SB     = 6'b101000,
    SH     = 6'b101001,
    SW     = 6'b101011,
    LL     = 6'b110000,
    SC     = 6'b111000
  } opcode_t;

endpackage

module decode_execute_latch
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        mem_busy,
  input  logic        flush,
  input  logic [31:0] fdInst,
  input  logic [31:0] fdPC,
  input  logic [31:0] rdat1,
  input  logic [31:0] rdat2,
  output logic [31:0] DEIFInst,
  output logic [31:0] DEIF_rdat1,
  output logic [31:0] DEIF_rdat2,
  output logic [31:0] DEIF_pc,
  output logic        DEIF_valid,
`ifdef PERF_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic        fd_stall
);

  typedef enum logic {StRun, StBubble} state_e;

  state_e      state_q;
  logic [31:0] inst_q;
  logic [31:0] rdat1_q;
  logic [31:0] rdat2_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        pend_flush_q;

  opcode_t     deif_op;
  logic [4:0]  deif_rt;
  logic        is_load;
  logic        load_use;
  logic        flush_eff;

  assign deif_op = opcode_t'(inst_q[31:26]);
  assign deif_rt = inst_q[20:16];

  always_comb begin
    is_load = 1'b0;
    case (deif_op)
      LW, LL:  is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  end

  // In StBubble the latch always holds a NOP, so gating on StRun only restates
  // that a single load can never produce a second consecutive bubble.
  always_comb begin
    load_use = (state_q == StRun) && valid_q && is_load && (deif_rt != 5'd0) &&
               ((deif_rt == fdInst[25:21]) || (deif_rt == fdInst[20:16]));
  end

  assign flush_eff = flush | pend_flush_q;
  assign fd_stall  = mem_busy | (load_use & ~flush_eff);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StRun;
      inst_q       <= '0;
      rdat1_q      <= '0;
      rdat2_q      <= '0;
      pc_q         <= '0;
      valid_q      <= 1'b0;
      pend_flush_q <= 1'b0;
    end else if (mem_busy) begin
      // Whole pipeline holds; remember a flush that arrived while frozen.
      if (flush) pend_flush_q <= 1'b1;
    end else if (flush_eff) begin
      state_q      <= StRun;
      inst_q       <= '0;
      rdat1_q      <= '0;
      rdat2_q      <= '0;
      pc_q         <= '0;
      valid_q      <= 1'b0;
      pend_flush_q <= 1'b0;
    end else if (load_use) begin
      state_q <= StBubble;
      inst_q  <= '0;
      rdat1_q <= '0;
      rdat2_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (ihit) begin
      state_q <= StRun;
      inst_q  <= fdInst;
      rdat1_q <= rdat1;
      rdat2_q <= rdat2;
      pc_q    <= fdPC;
      valid_q <= 1'b1;
    end else begin
      state_q <= StRun;
      inst_q  <= '0;
      rdat1_q <= '0;
      rdat2_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      bubble_cnt_q <= '0;
    end else if (!mem_busy && !flush_eff && load_use && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign DEIFInst   = inst_q;
  assign DEIF_rdat1 = rdat1_q;
  assign DEIF_rdat2 = rdat2_q;
  assign DEIF_pc    = pc_q;
  assign DEIF_valid = valid_q;

endmodule

// File: doc/decode_execute_latch.md
DECODE_EXECUTE_LATCH -- requirements
Module: decode_execute_latch

Interface
REQ-001 CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 ihit  in  1  fetch/decode latch holds a valid instruction this cycle.
REQ-004 mem_busy  in  1  memory stage waiting on dcache; whole pipeline holds.
REQ-005 flush  in  1  taken branch/jump resolved; squash younger instructions.
REQ-006 fdInst  in  32  instruction in fetch/decode latch.
REQ-007 fdPC  in  32  PC+4 of fdInst.
REQ-008 rdat1, rdat2  in  32 each  register file reads for fdInst rs/rt.
REQ-009 DEIFInst  out  32  latched instruction fed to execute and forwarding logic.
REQ-010 DEIF_rdat1, DEIF_rdat2, DEIF_pc  out  32 each  latched operands and PC+4.
REQ-011 DEIF_valid  out  1  latched entry is a real instruction (0 = bubble).
REQ-012 fd_stall  out  1  combinational; hold PC and fetch/decode latch this cycle.
REQ-013 bubble_cnt  out  16  load-use bubbles inserted (present only with PERF_CNT_EN).

Function
REQ-014 Opcodes shall be decoded with the shared cpu_types_pkg opcode enumeration.
REQ-015 Load-use hazard (comb) = DEIF_valid & DEIFInst[31:26] in {LW, LL} & DEIFInst[20:16] != 0 & (DEIFInst[20:16] == fdInst[25:21] | DEIFInst[20:16] == fdInst[20:16]).
REQ-016 fd_stall = mem_busy | (load-use hazard & ~flush_eff); flush_eff = flush | pend_flush.
REQ-017 Per-edge update priority: RST, then mem_busy, then flush_eff, then load-use, then ihit, else idle.
REQ-018 mem_busy=1: all outputs hold; state holds; if flush=1, pend_flush is set.
REQ-019 flush_eff=1 and mem_busy=0: load NOP bubble (all 32-bit outputs 0, DEIF_valid 0); clear pend_flush.
REQ-020 Load-use and mem_busy=0 and flush_eff=0: load NOP bubble; state -> BUBBLE; bubble_cnt increments.
REQ-021 ihit=1, no hazard, no flush, mem_busy=0: load fdInst, rdat1, rdat2, fdPC; DEIF_valid=1; state -> RUN.
REQ-022 ihit=0 with no higher-priority condition: load NOP bubble; state -> RUN.
REQ-023 State machine: RUN (normal), BUBBLE (load-use bubble inserted previous edge); BUBBLE -> RUN on any non-held edge.
REQ-024 A single load shall never produce more than one consecutive bubble (held DEIF after bubble is NOP, so hazard clears).
REQ-025 Latency: fdInst appears on DEIFInst one edge after acceptance; no combinational path from inputs to DEIF outputs.
REQ-026 bubble_cnt saturates at 16'hFFFF.

Reset
REQ-027 RST=1 at an edge: DEIFInst, DEIF_rdat1, DEIF_rdat2, DEIF_pc = 0; DEIF_valid=0; pend_flush=0; state=RUN; bubble_cnt=0.
REQ-028 RST shall override mem_busy and flush; reset mid-stall discards any pending flush.

Configuration
REQ-029 Macro PERF_CNT_EN defined: bubble_cnt port and counter present per REQ-020/026.
REQ-030 PERF_CNT_EN undefined: bubble_cnt port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset: RST=1 one edge with ihit=1, fdInst=32'h2008_0005 -> DEIFInst=0, DEIF_valid=0, state RUN.
REQ-032 Advance: ihit=1, fdInst=32'h0109_5020 (add), rdat1=5, rdat2=7, fdPC=32'h104 -> next edge DEIF holds those values, DEIF_valid=1, fd_stall=0.
REQ-033 Load-use: DEIF=LW $t0 (32'h8D28_0000), fdInst=add using $t0 -> fd_stall=1, next edge bubble, bubble_cnt=1; following edge add latched, fd_stall=0.
REQ-034 Rt=$zero load: DEIF=LW $0 (32'h8D20_0000), fdInst reads $0 -> fd_stall=0, no bubble.
REQ-035 Flush during mem_busy: mem_busy=1 and flush=1 one cycle, then mem_busy=0, flush=0, ihit=1 -> outputs held during busy, then NOP bubble loaded, pend_flush cleared.
REQ-036 Flush vs load-use same cycle: hazard and flush=1 -> bubble loaded, fd_stall=0, bubble_cnt unchanged.
